bp_update_queue: RTL and testbench

//  In-order tracker that produces the predictor's resolution/update stream. Dispatch allocates one

---
 rtl/bp_update_queue_if.sv | 80 ++++++++
 rtl/bp_update_queue.sv | 178 +++++++++++++++++
 tb/tb_bp_update_queue.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_update_queue_if.sv
// Dispatch/execute-facing bundle of the branch-predictor update queue, plus the
// predictor update and redirect outputs.
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

interface bp_update_queue_if #(
    parameter int DEPTH    = 16,
    parameter int GHR_BITS = `BP_GHR_BITS,
    parameter int ADDR_W   = `INST_ADDR_WIDTH
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                flush;

    logic                alloc_valid;
    logic                alloc_ready;
    logic [ADDR_W-1:0]   alloc_pc;
    logic                alloc_pred_taken;
    logic [ADDR_W-1:0]   alloc_pred_target;
    logic [GHR_BITS-1:0] alloc_hist;
    logic                alloc_is_call;
    logic                alloc_is_return;
    logic [IDX_W-1:0]    alloc_tag;

    logic                res_valid;
    logic [IDX_W-1:0]    res_tag;
    logic                res_taken;
    logic [ADDR_W-1:0]   res_target;

    logic                update0_valid;
    logic [ADDR_W-1:0]   update0_pc;
    logic                update0_taken;
    logic [ADDR_W-1:0]   update0_target;
    logic [GHR_BITS-1:0] update0_hist;
    logic                update0_is_call;
    logic                update0_is_return;

    logic                update1_valid;
    logic [ADDR_W-1:0]   update1_pc;
    logic                update1_taken;
    logic [ADDR_W-1:0]   update1_target;
    logic [GHR_BITS-1:0] update1_hist;
    logic                update1_is_call;
    logic                update1_is_return;

    logic                mispredict_valid;
    logic [ADDR_W-1:0]   mispredict_target;

    // Pipeline side: drives dispatch/execute, consumes updates and redirects.
    modport master (
        output flush,
        output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
               alloc_hist, alloc_is_call, alloc_is_return,
        input  alloc_ready, alloc_tag,
        output res_valid, res_tag, res_taken, res_target,
        input  update0_valid, update0_pc, update0_taken, update0_target,
               update0_hist, update0_is_call, update0_is_return,
        input  update1_valid, update1_pc, update1_taken, update1_target,
               update1_hist, update1_is_call, update1_is_return,
        input  mispredict_valid, mispredict_target
    );

    // Queue side.
    modport slave (
        input  flush,
        input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
               alloc_hist, alloc_is_call, alloc_is_return,
        output alloc_ready, alloc_tag,
        input  res_valid, res_tag, res_taken, res_target,
        output update0_valid, update0_pc, update0_taken, update0_target,
               update0_hist, update0_is_call, update0_is_return,
        output update1_valid, update1_pc, update1_taken, update1_target,
               update1_hist, update1_is_call, update1_is_return,
        output mispredict_valid, mispredict_target
    );
endinterface

// File: rtl/bp_update_queue.sv
// In-order branch resolution tracker: allocates at dispatch, resolves out of order,
// retires up to two entries per cycle to the predictor and redirects on mispredict.
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_ADD_STEP
`define INST_ADD_STEP 4
`endif

module bp_update_queue #(
    parameter int DEPTH    = 16,
    parameter int GHR_BITS = `BP_GHR_BITS,
    parameter int ADDR_W   = `INST_ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    bp_update_queue_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [GHR_BITS-1:0] hist_t;

    typedef struct packed {
        addr_t pc;
        logic  pred_taken;
        addr_t pred_target;
        hist_t hist;
        logic  is_call;
        logic  is_return;
    } info_t;

    typedef struct packed {
        logic  taken;
        addr_t target;
    } outcome_t;

    info_t            info    [DEPTH];
    outcome_t         outcome [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    idx_t             head;
    idx_t             tail;
    cnt_t             count;

    function automatic logic is_mispredict(input info_t e, input outcome_t r);
        return (r.taken != e.pred_taken) || (r.taken && (r.target != e.pred_target));
    endfunction

    function automatic addr_t redirect_of(input info_t e, input outcome_t r);
        return r.taken ? r.target : e.pc + addr_t'(`INST_ADD_STEP);
    endfunction

    idx_t     head_p1;
    info_t    info0, info1;
    outcome_t out0, out1;
    logic     ret0, ret1, mp0, mp1, clear, full, alloc_fire, res_fire;
    logic [1:0] n_ret;

    assign head_p1 = head + idx_t'(1);
    assign info0   = info[head];
    assign info1   = info[head_p1];
    assign out0    = outcome[head];
    assign out1    = outcome[head_p1];

    // Slot1 only follows a correctly predicted slot0; a slot0 redirect kills everything younger.
    assign ret0  = busy[head] && done[head];
    assign mp0   = is_mispredict(info0, out0);
    assign ret1  = ret0 && !mp0 && busy[head_p1] && done[head_p1];
    assign mp1   = is_mispredict(info1, out1);
    assign clear = (ret0 && mp0) || (ret1 && mp1);
    assign n_ret = {1'b0, ret0} + {1'b0, ret1};

    assign full       = (count == cnt_t'(DEPTH));
    assign alloc_fire = bus.alloc_valid && !full && !bus.flush && !clear;
    assign res_fire   = bus.res_valid && busy[bus.res_tag];

    assign bus.alloc_ready = !full;
    assign bus.alloc_tag   = tail;

    // NOTE: payload storage carries no reset; busy/done alone decide whether a slot holds anything.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            info[tail] <= '{pc:          bus.alloc_pc,
                            pred_taken:  bus.alloc_pred_taken,
                            pred_target: bus.alloc_pred_target,
                            hist:        bus.alloc_hist,
                            is_call:     bus.alloc_is_call,
                            is_return:   bus.alloc_is_return};
        end
        if (res_fire) begin
            outcome[bus.res_tag] <= '{taken: bus.res_taken, target: bus.res_target};
        end
    end

    // NOTE: non-blocking assignments here let the later retire clears override an earlier
    // done-set on the same slot within one edge, exactly as the last write wins.
    always_ff @(posedge clk) begin
        if (rst || bus.flush || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
        end else begin
            if (alloc_fire) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + idx_t'(1);
            end
            if (res_fire) begin
                done[bus.res_tag] <= 1'b1;
            end
            if (ret0) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
            end
            if (ret1) begin
                busy[head_p1] <= 1'b0;
                done[head_p1] <= 1'b0;
            end
            head  <= head + idx_t'(n_ret);
            count <= count - cnt_t'(n_ret) + cnt_t'(alloc_fire);
        end
    end

    // Valids pulse for one cycle; payloads hold their last value between retirements.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.update0_valid     <= 1'b0;
            bus.update0_pc        <= '0;
            bus.update0_taken     <= 1'b0;
            bus.update0_target    <= '0;
            bus.update0_hist      <= '0;
            bus.update0_is_call   <= 1'b0;
            bus.update0_is_return <= 1'b0;
            bus.update1_valid     <= 1'b0;
            bus.update1_pc        <= '0;
            bus.update1_taken     <= 1'b0;
            bus.update1_target    <= '0;
            bus.update1_hist      <= '0;
            bus.update1_is_call   <= 1'b0;
            bus.update1_is_return <= 1'b0;
            bus.mispredict_valid  <= 1'b0;
            bus.mispredict_target <= '0;
        end else begin
            bus.update0_valid    <= ret0;
            bus.update1_valid    <= ret1;
            bus.mispredict_valid <= clear;
            if (ret0) begin
                bus.update0_pc        <= info0.pc;
                bus.update0_taken     <= out0.taken;
                bus.update0_target    <= out0.target;
                bus.update0_hist      <= info0.hist;
                bus.update0_is_call   <= info0.is_call;
                bus.update0_is_return <= info0.is_return;
            end
            if (ret1) begin
                bus.update1_pc        <= info1.pc;
                bus.update1_taken     <= out1.taken;
                bus.update1_target    <= out1.target;
                bus.update1_hist      <= info1.hist;
                bus.update1_is_call   <= info1.is_call;
                bus.update1_is_return <= info1.is_return;
            end
            if (clear) begin
                bus.mispredict_target <= (ret0 && mp0) ? redirect_of(info0, out0)
                                                       : redirect_of(info1, out1);
            end
        end
    end
endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: a vector table for single/dual retire, mispredict,
// flush and reset cases, plus hand sequences for fill, wrap-around and in-order drain.
module tb_bp_update_queue;
    typedef logic [31:0] addr_t;
    typedef logic [7:0]  hist_t;
    typedef logic [3:0]  tag_t;

    typedef struct packed {
        logic rs; logic fl;
        logic av; addr_t apc; logic apt; addr_t atgt; hist_t ah; logic [1:0] acr;
        logic rv; tag_t rtag; logic rt; addr_t rtgt;
    } stim_t;

    typedef struct packed {
        logic rdy; tag_t tag;
        logic u0v; addr_t u0pc; logic u0t; addr_t u0tgt; hist_t u0h; logic [1:0] u0cr;
        logic u1v; addr_t u1pc; logic u1t; addr_t u1tgt;
        logic mpv; addr_t mpt;
    } exp_t;

    typedef struct packed { stim_t s; exp_t e; } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   retired = 0;
    addr_t exp_q[$];
    vec_t  vecs[$];

    always #5 clk = ~clk;

    bp_update_queue_if #(.DEPTH(16), .GHR_BITS(8), .ADDR_W(32)) bus ();

    bp_update_queue #(.DEPTH(16), .GHR_BITS(8), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic stim_t s_idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t s_rst();
        stim_t s;
        s = '0;
        s.rs = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_alloc(addr_t pc, logic pt, addr_t tgt, hist_t h, logic [1:0] cr);
        stim_t s;
        s = '0;
        s.av = 1'b1; s.apc = pc; s.apt = pt; s.atgt = tgt; s.ah = h; s.acr = cr;
        return s;
    endfunction

    function automatic stim_t s_res(tag_t tag, logic t, addr_t tgt);
        stim_t s;
        s = '0;
        s.rv = 1'b1; s.rtag = tag; s.rt = t; s.rtgt = tgt;
        return s;
    endfunction

    function automatic exp_t e_idle(logic rdy, tag_t tag);
        exp_t e;
        e = '0;
        e.rdy = rdy; e.tag = tag;
        return e;
    endfunction

    function automatic exp_t e_ret(logic rdy, tag_t tag,
                                   addr_t u0pc, logic u0t, addr_t u0tgt, hist_t u0h, logic [1:0] u0cr,
                                   logic u1v, addr_t u1pc, logic u1t, addr_t u1tgt,
                                   logic mpv, addr_t mpt);
        exp_t e;
        e = '0;
        e.rdy = rdy; e.tag = tag;
        e.u0v = 1'b1; e.u0pc = u0pc; e.u0t = u0t; e.u0tgt = u0tgt; e.u0h = u0h; e.u0cr = u0cr;
        e.u1v = u1v; e.u1pc = u1pc; e.u1t = u1t; e.u1tgt = u1tgt;
        e.mpv = mpv; e.mpt = mpt;
        return e;
    endfunction

    function automatic void add(stim_t s, exp_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(input stim_t s);
        rst                   = s.rs;
        bus.flush             = s.fl;
        bus.alloc_valid       = s.av;
        bus.alloc_pc          = s.apc;
        bus.alloc_pred_taken  = s.apt;
        bus.alloc_pred_target = s.atgt;
        bus.alloc_hist        = s.ah;
        bus.alloc_is_call     = s.acr[1];
        bus.alloc_is_return   = s.acr[0];
        bus.res_valid         = s.rv;
        bus.res_tag           = s.rtag;
        bus.res_taken         = s.rt;
        bus.res_target        = s.rtgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input int idx, input exp_t e);
        logic ok;
        ok = (bus.alloc_ready === e.rdy) && (bus.alloc_tag === e.tag) &&
             (bus.update0_valid === e.u0v) && (bus.update1_valid === e.u1v) &&
             (bus.mispredict_valid === e.mpv);
        if (e.u0v)
            ok = ok && (bus.update0_pc === e.u0pc) && (bus.update0_taken === e.u0t) &&
                 (bus.update0_target === e.u0tgt) && (bus.update0_hist === e.u0h) &&
                 ({bus.update0_is_call, bus.update0_is_return} === e.u0cr);
        if (e.u1v)
            ok = ok && (bus.update1_pc === e.u1pc) && (bus.update1_taken === e.u1t) &&
                 (bus.update1_target === e.u1tgt);
        if (e.mpv)
            ok = ok && (bus.mispredict_target === e.mpt);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL vec%0d: got rdy=%0b tag=%0d u0v=%0b u0pc=%0h u0t=%0b u0tgt=%0h u0h=%0h u1v=%0b u1pc=%0h mpv=%0b mpt=%0h; expected rdy=%0b tag=%0d u0v=%0b u0pc=%0h u0t=%0b u0tgt=%0h u0h=%0h u1v=%0b u1pc=%0h mpv=%0b mpt=%0h",
                     idx, bus.alloc_ready, bus.alloc_tag, bus.update0_valid, bus.update0_pc,
                     bus.update0_taken, bus.update0_target, bus.update0_hist, bus.update1_valid,
                     bus.update1_pc, bus.mispredict_valid, bus.mispredict_target,
                     e.rdy, e.tag, e.u0v, e.u0pc, e.u0t, e.u0tgt, e.u0h, e.u1v, e.u1pc, e.mpv, e.mpt);
        end
    endtask

    // Clock once and match any retired pcs against the expected program order.
    task automatic tick_mon();
        tick();
        if (bus.mispredict_valid) check("unexpected_redirect", 64'(bus.mispredict_valid), 64'd0);
        if (bus.update0_valid) begin
            if (exp_q.size() == 0) check("u0_extra", 64'(bus.update0_pc), 64'hffff_ffff_ffff);
            else check("order_u0", 64'(bus.update0_pc), 64'(exp_q.pop_front()));
            retired++;
        end
        if (bus.update1_valid) begin
            if (exp_q.size() == 0) check("u1_extra", 64'(bus.update1_pc), 64'hffff_ffff_ffff);
            else check("order_u1", 64'(bus.update1_pc), 64'(exp_q.pop_front()));
            retired++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive(s_rst());
        tick();
        tick();
        drive(s_idle());
        tick();
        check("rst_ready", 64'(bus.alloc_ready), 64'd1);
        check("rst_tag", 64'(bus.alloc_tag), 64'd0);
        check("rst_u0v", 64'(bus.update0_valid), 64'd0);
        check("rst_u0pc", 64'(bus.update0_pc), 64'd0);
        check("rst_u1v", 64'(bus.update1_valid), 64'd0);
        check("rst_mpv", 64'(bus.mispredict_valid), 64'd0);
        check("rst_mpt", 64'(bus.mispredict_target), 64'd0);

        // Single retire, not-taken, call flag carried through.
        add(s_alloc(32'h100, 1'b0, 32'h0, 8'h03, 2'b10), e_idle(1, 1));
        add(s_res(0, 1'b0, 32'h0),                       e_idle(1, 1));
        add(s_idle(), e_ret(1, 1, 32'h100, 0, 32'h0, 8'h03, 2'b10, 0, 0, 0, 0, 0, 0));
        add(s_idle(),                                    e_idle(1, 1));
        // Out-of-order resolve, dual retire in one cycle.
        add(s_rst(),                                     e_idle(1, 0));
        add(s_alloc(32'h100, 1'b1, 32'h200, 8'h11, 2'b00), e_idle(1, 1));
        add(s_alloc(32'h104, 1'b1, 32'h300, 8'h12, 2'b10), e_idle(1, 2));
        add(s_res(1, 1'b1, 32'h300),                     e_idle(1, 2));
        add(s_res(0, 1'b1, 32'h200),                     e_idle(1, 2));
        add(s_idle(), e_ret(1, 2, 32'h100, 1, 32'h200, 8'h11, 2'b00, 1, 32'h104, 1, 32'h300, 0, 0));
        add(s_idle(),                                    e_idle(1, 2));
        // Slot0 mispredict clears the queue despite a same-cycle resolve of the younger entry.
        add(s_rst(),                                     e_idle(1, 0));
        add(s_alloc(32'h100, 1'b0, 32'h0, 8'h21, 2'b00), e_idle(1, 1));
        add(s_alloc(32'h104, 1'b0, 32'h0, 8'h22, 2'b00), e_idle(1, 2));
        add(s_res(0, 1'b1, 32'h180),                     e_idle(1, 2));
        add(s_res(1, 1'b0, 32'h0), e_ret(1, 0, 32'h100, 1, 32'h180, 8'h21, 2'b00, 0, 0, 0, 0, 1, 32'h180));
        add(s_idle(),                                    e_idle(1, 0));
        // Slot1 mispredict: both retire, same-cycle alloc dropped, third entry discarded.
        add(s_rst(),                                     e_idle(1, 0));
        add(s_alloc(32'h200, 1'b0, 32'h0, 8'h01, 2'b00), e_idle(1, 1));
        add(s_alloc(32'h204, 1'b0, 32'h0, 8'h02, 2'b01), e_idle(1, 2));
        add(s_alloc(32'h208, 1'b0, 32'h0, 8'h03, 2'b00), e_idle(1, 3));
        add(s_res(1, 1'b1, 32'h280),                     e_idle(1, 3));
        add(s_res(0, 1'b0, 32'h0),                       e_idle(1, 3));
        add(s_alloc(32'h300, 1'b0, 32'h0, 8'h04, 2'b00),
            e_ret(1, 0, 32'h200, 0, 32'h0, 8'h01, 2'b00, 1, 32'h204, 1, 32'h280, 1, 32'h280));
        add(s_res(2, 1'b0, 32'h0),                       e_idle(1, 0));
        add(s_idle(),                                    e_idle(1, 0));
        // Redirect targets: fall-through for wrong taken, actual target for wrong destination.
        add(s_rst(),                                     e_idle(1, 0));
        add(s_alloc(32'h120, 1'b1, 32'h200, 8'h05, 2'b00), e_idle(1, 1));
        add(s_res(0, 1'b0, 32'h0),                       e_idle(1, 1));
        add(s_idle(), e_ret(1, 0, 32'h120, 0, 32'h0, 8'h05, 2'b00, 0, 0, 0, 0, 1, 32'h124));
        add(s_alloc(32'h140, 1'b1, 32'h200, 8'h06, 2'b00), e_idle(1, 1));
        add(s_res(0, 1'b1, 32'h240),                     e_idle(1, 1));
        add(s_idle(), e_ret(1, 0, 32'h140, 1, 32'h240, 8'h06, 2'b00, 0, 0, 0, 0, 1, 32'h240));
        add(s_idle(),                                    e_idle(1, 0));
        // Flush with a done head entry and a pending resolve; then reset during a retire.
        add(s_rst(),                                     e_idle(1, 0));
        for (int i = 0; i < 5; i++)
            add(s_alloc(32'h500 + 32'(4 * i), 1'b0, 32'h0, 8'h00, 2'b00), e_idle(1, tag_t'(i + 1)));
        add(s_res(0, 1'b0, 32'h0),                       e_idle(1, 5));
        begin
            stim_t fs;
            fs = s_res(1, 1'b0, 32'h0);
            fs.fl = 1'b1;
            add(fs,                                      e_idle(1, 0));
        end
        add(s_idle(),                                    e_idle(1, 0));
        add(s_alloc(32'h600, 1'b0, 32'h0, 8'h00, 2'b00), e_idle(1, 1));
        add(s_idle(),                                    e_idle(1, 1));
        add(s_res(0, 1'b0, 32'h0),                       e_idle(1, 1));
        add(s_rst(),                                     e_idle(1, 0));
        add(s_idle(),                                    e_idle(1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].s);
            tick();
            check_vec(i, vecs[i].e);
        end

        // Fill to full, attempt an extra alloc, retire three, wrap the tail, drain in order.
        drive(s_rst());
        tick();
        drive(s_idle());
        for (int i = 0; i < 16; i++) begin
            check("fill_tag", 64'(bus.alloc_tag), 64'(i));
            drive(s_alloc(32'h1000 + 32'(4 * i), 1'b0, 32'h0, 8'(i), 2'b00));
            exp_q.push_back(32'h1000 + 32'(4 * i));
            tick();
        end
        check("full_ready", 64'(bus.alloc_ready), 64'd0);
        check("full_tag", 64'(bus.alloc_tag), 64'd0);
        drive(s_alloc(32'hdead, 1'b0, 32'h0, 8'h00, 2'b00));
        tick();
        check("full_drop_tag", 64'(bus.alloc_tag), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(s_res(tag_t'(i), 1'b0, 32'h0));
            tick_mon();
            if (i == 0) check("full_no_bypass", 64'(bus.alloc_ready), 64'd0);
        end
        drive(s_idle());
        for (int k = 0; k < 10 && retired < 3; k++) tick_mon();
        check("first_retired", 64'(retired), 64'd3);
        check("wrap_ready", 64'(bus.alloc_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("wrap_tag", 64'(bus.alloc_tag), 64'(i));
            drive(s_alloc(32'h2000 + 32'(4 * i), 1'b0, 32'h0, 8'h00, 2'b00));
            exp_q.push_back(32'h2000 + 32'(4 * i));
            tick_mon();
        end
        check("refull_ready", 64'(bus.alloc_ready), 64'd0);
        check("refull_tag", 64'(bus.alloc_tag), 64'd3);
        for (int i = 0; i < 16; i++) begin
            drive(s_res(tag_t'(i + 3), 1'b0, 32'h0));
            tick_mon();
        end
        drive(s_idle());
        for (int k = 0; k < 20 && retired < 19; k++) tick_mon();
        check("drain_retired", 64'(retired), 64'd19);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_ready", 64'(bus.alloc_ready), 64'd1);
        check("drain_tag", 64'(bus.alloc_tag), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
